// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        FETCH_AR = 2'd0,
        FETCH_R  = 2'd1,
        SEND     = 2'd2,
        WAIT_PC  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_timeout_cnt.sv
// Saturating 8-bit wait counter for the read-data phase; flags expiry at TIMEOUT.
module ifu_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count_r;

    // Count enabled cycles, clear has priority, hold at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 8'd0;
        end else if (clr) begin
            count_r <= 8'd0;
        end else if (en && (count_r != 8'hFF)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one AXI4-Lite read per PC, handed to decode over valid/ready.
// The next fetch waits for decode to supply the PC; there is no speculation.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    input  logic        pc_write_enable,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        ifu_send_valid,
    input  logic        ifu_receive_ready,
    output logic        fetch_error
);

    ifu_state_e  state_r, state_next_s;
    logic [31:0] fetch_pc_r, fetch_pc_next_s;
    logic [31:0] pending_pc_r;
    logic        pending_r;
    logic [31:0] instruction_r, pc_r;
    logic        arvalid_r, rready_r, send_valid_r, fetch_error_r;
    logic        arvalid_next_s, rready_next_s, send_valid_next_s;
    logic        capture_s, timed_out_s, misaligned_s;
    logic        cnt_clr_s, cnt_en_s, expired_s;

    assign cnt_en_s  = (state_r == FETCH_R);
    assign cnt_clr_s = (state_r != FETCH_R) || capture_s;

    ifu_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .expired (expired_s)
    );

    // Next-state and next fetch-PC selection
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        capture_s       = 1'b0;
        timed_out_s     = 1'b0;
        misaligned_s    = 1'b0;
        case (state_r)
            FETCH_AR: begin
                if (!is_aligned(fetch_pc_r)) begin
                    misaligned_s = 1'b1;
                    state_next_s = SEND;
                end else if (arvalid_r && arready) begin
                    state_next_s = FETCH_R;
                end else begin
                    state_next_s = FETCH_AR;
                end
            end
            FETCH_R: begin
                if (rvalid && rready_r) begin
                    capture_s    = 1'b1;
                    state_next_s = SEND;
                end else if (expired_s) begin
                    timed_out_s  = 1'b1;
                    state_next_s = SEND;
                end else begin
                    state_next_s = FETCH_R;
                end
            end
            SEND: begin
                if (send_valid_r && ifu_receive_ready) begin
                    state_next_s = WAIT_PC;
                end else begin
                    state_next_s = SEND;
                end
            end
            WAIT_PC: begin
                // A fresh strobe beats a redirect that arrived earlier
                if (pc_write_enable) begin
                    fetch_pc_next_s = pc_next;
                    state_next_s    = FETCH_AR;
                end else if (pending_r) begin
                    fetch_pc_next_s = pending_pc_r;
                    state_next_s    = FETCH_AR;
                end else begin
                    state_next_s = WAIT_PC;
                end
            end
            default: begin
                state_next_s = FETCH_AR;
            end
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they leave a flop
    always_comb begin
        arvalid_next_s    = (state_next_s == FETCH_AR) && is_aligned(fetch_pc_next_s);
        // After a timeout rready lingers one cycle to swallow a late response
        rready_next_s     = (state_next_s == FETCH_R) || timed_out_s;
        send_valid_next_s = (state_next_s == SEND);
    end

    // State, datapath and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FETCH_AR;
            fetch_pc_r    <= RESET_PC;
            pending_pc_r  <= 32'h0000_0000;
            pending_r     <= 1'b0;
            instruction_r <= 32'h0000_0000;
            pc_r          <= 32'h0000_0000;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            send_valid_r  <= 1'b0;
            fetch_error_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            fetch_pc_r   <= fetch_pc_next_s;
            arvalid_r    <= arvalid_next_s;
            rready_r     <= rready_next_s;
            send_valid_r <= send_valid_next_s;
            if (capture_s) begin
                pc_r <= fetch_pc_r;
                if (rresp == RESP_OKAY) begin
                    instruction_r <= rdata;
                end else begin
                    instruction_r <= EBREAK_INSN;
                    fetch_error_r <= 1'b1;
                end
            end else if (misaligned_s || timed_out_s) begin
                pc_r          <= fetch_pc_r;
                instruction_r <= EBREAK_INSN;
                fetch_error_r <= 1'b1;
            end else begin
                pc_r          <= pc_r;
                instruction_r <= instruction_r;
            end
            if (pc_write_enable && (state_r != WAIT_PC)) begin
                pending_pc_r <= pc_next;
                pending_r    <= 1'b1;
            end else if (state_r == WAIT_PC) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign araddr         = fetch_pc_r;
    assign arvalid        = arvalid_r;
    assign rready         = rready_r;
    assign instruction    = instruction_r;
    assign pc             = pc_r;
    assign ifu_send_valid = send_valid_r;
    assign fetch_error    = fetch_error_r;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: randomized memory slave plus a transaction-level
// decode model that predicts each delivered PC/instruction and the sticky error.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TMO    = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_next = 32'h0;
    logic        pc_write_enable = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        ifu_send_valid;
    logic        ifu_receive_ready = 1'b0;
    logic        fetch_error;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_next           (pc_next),
        .pc_write_enable   (pc_write_enable),
        .araddr            (araddr),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rvalid            (rvalid),
        .rready            (rready),
        .instruction       (instruction),
        .pc                (pc),
        .ifu_send_valid    (ifu_send_valid),
        .ifu_receive_ready (ifu_receive_ready),
        .fetch_error       (fetch_error)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RST_PC) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pick_next(input logic [31:0] cur);
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return (cur & 32'hFFFF_FFFC) + 32'd6;
        if (r == 1) return 32'h8000_0000 | ($urandom() & 32'h0000_FFFC);
        return (cur & 32'hFFFF_FFFC) + 32'd4;
    endfunction

    // Slave plan for the next read: 0 okay, 1 error response, 2 never respond
    int          plan_ar_dly = 0;
    int          plan_r_dly  = 0;
    int          plan_kind   = 0;
    logic [31:0] addr_q[$];
    logic [31:0] s_addr;
    int          s_n;

    initial begin : slave
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst && arvalid) begin
                s_addr = araddr;
                for (int i = 0; i < plan_ar_dly; i++) begin
                    @(negedge clk);
                    check("arvalid_hold", 32'(arvalid), 32'd1);
                    check("araddr_hold", araddr, s_addr);
                end
                arready = 1'b1;
                @(negedge clk);
                arready = 1'b0;
                addr_q.push_back(s_addr);
                if (plan_kind == 2) begin
                    s_n = 0;
                    while (rready === 1'b1 && s_n < 400) begin
                        s_n++;
                        @(negedge clk);
                    end
                    check("timeout_rready_cycles", 32'((s_n >= TMO + 1) && (s_n <= TMO + 2)), 32'd1);
                end else begin
                    for (int i = 0; i < plan_r_dly; i++) @(negedge clk);
                    check("rready_wait", 32'(rready), 32'd1);
                    rvalid = 1'b1;
                    rdata  = mem_word(s_addr);
                    rresp  = (plan_kind == 1) ? 2'b10 : 2'b00;
                    @(negedge clk);
                    rvalid = 1'b0;
                    rdata  = $urandom();
                    rresp  = 2'b00;
                end
            end
        end
    end

    logic [31:0] exp_pc;
    logic        err_exp;

    task automatic wait_send(input int limit, output int cycles);
        cycles = 0;
        while (ifu_send_valid !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_write_enable = 1'b0;
        ifu_receive_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_send_valid", 32'(ifu_send_valid), 32'd0);
        check("rst_fetch_error", 32'(fetch_error), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        addr_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("arvalid_after_rst", 32'(arvalid), 32'd1);
        check("araddr_after_rst", araddr, RST_PC);
    endtask

    task automatic strobe(input logic [31:0] v);
        pc_write_enable = 1'b1;
        pc_next = v;
        @(negedge clk);
        pc_write_enable = 1'b0;
        pc_next = $urandom();
    endtask

    task automatic run_phase(input int ph, input int ntx);
        int          kind, nkind, hold, mode, c;
        bit          dbl, fault;
        logic [31:0] next_pc, snap_i, snap_p;
        exp_pc = RST_PC;
        err_exp = 1'b0;
        kind = 0;
        plan_ar_dly = 0;
        plan_r_dly = 0;
        plan_kind = 0;
        do_reset();
        for (int t = 0; t < ntx; t++) begin
            wait_send(600, c);
            check("send_seen", 32'(ifu_send_valid), 32'd1);
            if (ifu_send_valid !== 1'b1) finish_run();
            if (t == 0) check("send_latency", 32'(c), 32'd2);

            fault = !is_aligned(exp_pc) || (kind != 0);
            if (fault) err_exp = 1'b1;
            check("instruction", instruction, fault ? EBREAK_INSN : mem_word(exp_pc));
            if (is_aligned(exp_pc) && kind != 2) check("pc", pc, exp_pc);
            check("fetch_error", 32'(fetch_error), 32'(err_exp));
            if (is_aligned(exp_pc)) begin
                check("ar_count", 32'(addr_q.size()), 32'd1);
                if (addr_q.size() > 0) check("araddr", addr_q.pop_front(), exp_pc);
            end else begin
                check("ar_count_misaligned", 32'(addr_q.size()), 32'd0);
                addr_q.delete();
            end

            next_pc = pick_next(exp_pc);
            nkind = (ph == 0 || ph == 3) && ($urandom_range(0, 7) == 0) ? 1 : 0;
            hold = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            dbl = 1'($urandom_range(0, 1));
            if (ph == 0 && t == 0) begin
                hold = 5; mode = 1; dbl = 1'b0; next_pc = 32'h8000_0100; nkind = 1;
            end
            if (ph == 0 && t == 1) begin
                nkind = 0; next_pc = 32'h8000_0104;
            end
            if ((ph == 1 || ph == 2) && t == 0) begin
                nkind = (ph == 2) ? 2 : 0;
                next_pc = (ph == 1) ? 32'h8000_0102 : 32'h8000_0004;
            end
            if (!is_aligned(next_pc)) nkind = 0;
            if (t == ntx - 1) mode = 3;
            plan_kind = nkind;
            plan_ar_dly = $urandom_range(0, 2);
            plan_r_dly = $urandom_range(0, 3);

            snap_i = instruction;
            snap_p = pc;
            ifu_receive_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(ifu_send_valid), 32'd1);
                check("hold_instruction", instruction, snap_i);
                check("hold_pc", pc, snap_p);
                check("hold_arvalid", 32'(arvalid), 32'd0);
            end
            if (mode == 1) begin
                if (dbl) strobe(next_pc ^ 32'h0000_0040);
                strobe(next_pc);
            end else if (mode == 2) begin
                strobe(next_pc ^ 32'h0000_0080);
            end
            ifu_receive_ready = 1'b1;
            @(negedge clk);
            ifu_receive_ready = 1'b0;
            check("valid_drop", 32'(ifu_send_valid), 32'd0);
            if (mode == 0) begin
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                    @(negedge clk);
                    check("wait_arvalid", 32'(arvalid), 32'd0);
                end
                strobe(next_pc);
            end else if (mode == 2) begin
                strobe(next_pc);
            end
            exp_pc = next_pc;
            kind = nkind;
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin : main
        run_phase(0, 12);
        run_phase(1, 6);
        run_phase(2, 5);
        run_phase(3, 150);
        finish_run();
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the multi-cycle pipelined RV32 core. Holds the architectural fetch PC, reads one 32-bit instruction per PC over an AXI4-Lite read channel, and presents it with its PC to the decode stage through a valid/ready handshake. It fetches the next instruction only after decode has resolved the next PC and written it back (`pc_write_enable` / `pc_next`). There is no speculative fetch.

## Interface
- `RESET_PC`, default 32'h8000_0000: fetch PC after reset.
- `TIMEOUT`, default 255: maximum cycles spent waiting for `rvalid` before a fetch error is declared.

- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `pc_next`  in  32  next PC from decode
- `pc_write_enable`  in  1  one-cycle strobe; `pc_next` is valid
- `araddr`  out  32  read address
- `arvalid`  out  1  read address valid
- `arready`  in  1  read address accepted
- `rdata`  in  32  read data
- `rresp`  in  2  read response; 2'b00 means OKAY
- `rvalid`  in  1  read data valid
- `rready`  out  1  read data ready
- `instruction`  out  32  fetched instruction to decode
- `pc`  out  32  PC of `instruction`
- `ifu_send_valid`  out  1  `instruction`/`pc` valid to decode
- `ifu_receive_ready`  in  1  decode accepts
- `fetch_error`  out  1  sticky error flag

## Operation
**States:** FETCH_AR, FETCH_R, SEND, WAIT_PC.

**Reset values:**
- state = FETCH_AR, fetch PC = `RESET_PC`.
- `pc` = 0, `instruction` = 0.
- `arvalid` = `rready` = `ifu_send_valid` = `fetch_error` = 0.
- pending-PC flag = 0, timeout counter = 0.

**FETCH_AR**
- If fetch PC[1:0] != 0 (misaligned): no bus request is issued. Set `fetch_error`, load `instruction` = EBREAK (32'h0010_0073), go to SEND.
- Otherwise: `arvalid` = 1, `araddr` = fetch PC.
- `arvalid` and `araddr` stay stable until `arvalid && arready`, then go to FETCH_R.

**FETCH_R**
- `rready` = 1. The timeout counter increments each cycle.
- On `rvalid`:
  - Capture `rdata` into `instruction` and the fetch PC into `pc`.
  - If `rresp` != 0, substitute EBREAK and set `fetch_error`.
  - Clear the counter and go to SEND.
- If the counter reaches `TIMEOUT` without `rvalid`: EBREAK, `fetch_error`, go to SEND. Any late `rvalid` is accepted and discarded while `rready` stays 1 for the following 1 cycle only; beyond that its behaviour is undefined.

**SEND**
- `ifu_send_valid` = 1. `instruction` and `pc` are held stable until `ifu_send_valid && ifu_receive_ready`.
- After the transfer, drop valid and go to WAIT_PC.

**WAIT_PC**
- On `pc_write_enable`, or if the pending flag is set: fetch PC <= the strobed or pending value, clear the flag, go to FETCH_AR.

**Boundary rules**
- `pc_write_enable` arriving in any state other than WAIT_PC: latch `pc_next` into the pending register and set the flag. A later strobe overwrites an earlier one, last wins.
- A strobe and the pending flag both present in WAIT_PC: the strobe wins.
- `fetch_error` is sticky until `rst`.
- `rst` mid-transaction abandons the bus transaction. The interconnect is reset by the same `rst`.
- `pc_next[1:0]` is not masked. Alignment is checked in FETCH_AR.

## Timing
- Reset release to `arvalid` = 1: first cycle after `rst` deasserts.
- Zero-wait memory (`arready` and `rvalid` each high on the first cycle asked): the FETCH_AR→FETCH_R handshake, the data capture and SEND valid each take one cycle. `ifu_send_valid` rises 2 cycles after `arvalid` rises.
- Minimum loop per instruction: 1 cycle FETCH_AR + 1 cycle FETCH_R + ≥1 cycle SEND + ≥1 cycle WAIT_PC = 4 cycles, plus decode latency.
- `arvalid`, `rready` and `ifu_send_valid` are registered, decoded from the state register. They have no combinational path from any input.

## Structure
- Package `ifu_pkg`:
  - state enum (2 bits)
  - `EBREAK_INSN` = 32'h0010_0073
  - `RESP_OKAY` = 2'b00
  - default `RESET_PC`
- One natural sub-module: `ifu_timeout_cnt`. It is an 8-bit saturating counter with clear and enable, and outputs `expired` when count == `TIMEOUT`.
- Everything else lives in one always_ff block for the FSM and datapath registers, plus output assigns.

## Test plan
1. **Reset, zero-wait memory.** Release `rst` with `rdata` = 32'h0000_0013 → `araddr` = 32'h8000_0000 and `ifu_send_valid` rises 2 cycles after `arvalid`. `pc` = 32'h8000_0000, `instruction` = 32'h0000_0013.
2. **Backpressure.** Hold `ifu_receive_ready` = 0 for 5 cycles in SEND → `instruction` and `pc` are stable, `arvalid` stays 0. Raise ready → transfer, then WAIT_PC.
3. **Early redirect.** Pulse `pc_write_enable` with `pc_next` = 32'h8000_0100 during SEND → on entering WAIT_PC the next `araddr` = 32'h8000_0100 with no extra strobe.
4. **Bus error.** Drive `rresp` = 2'b10 → `instruction` = 32'h0010_0073 and `fetch_error` = 1, still set after the next normal fetch.
5. **Misaligned PC.** Set `pc_next` = 32'h8000_0102 → no `arvalid`, EBREAK sent to decode, `fetch_error` = 1.
6. **Timeout.** Leave `rvalid` = 0 → after 255 cycles in FETCH_R, EBREAK is delivered and `fetch_error` = 1.
